axi_stall_injector: RTL and testbench
=====================================

Name: axi_stall_injector

Overview:
- Per-channel valid/ready throttle placed between an AXI master (e.g. top_axi_int) and a slave (e.g. the AXI-to-RAM model) in simulation benches and FPGA stress builds.
- Generalises the per-channel random gating used in the int2ram bench to N channels, four runtime modes and a synthesizable LFSR.
- Guarantees AXI valid stability: once a valid has been shown downstream, it is never withdrawn.
- Data/ID/last buses bypass the block unchanged; only the handshake signals pass through it.

Parameters:
- N_CH, 5, number of handshake channels (default order AR, R, AW, W, B).
- PROB_W, 10, probability resolution in bits; prob field is PROB_W+1 bits wide.
- CNT_W, 8, width of the periodic-mode on/off length fields.
- SEED, 32'hACE1_2024, base LFSR seed; channel i seeds with SEED ^ (i*32'h9E37_79B9), forced to 1 if the result is zero.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- src_valid  in  N_CH  valid from the channel source.
- src_ready  out  N_CH  ready to the channel source.
- dst_valid  out  N_CH  valid to the channel sink.
- dst_ready  in  N_CH  ready from the channel sink.
- mode  in  2*N_CH  per-channel mode: 0 pass, 1 random, 2 periodic, 3 stall.
- prob  in  (PROB_W+1)*N_CH  per-channel enable probability, scaled by 2^PROB_W.
- on_len  in  CNT_W*N_CH  periodic-mode open cycles.
- off_len  in  CNT_W*N_CH  periodic-mode closed cycles.

Behaviour:
- Per channel i:
  - Registered enable en[i].
  - Flag committed[i].
  - 32-bit Galois LFSR lfsr[i], taps 0x8020_0003.
  - CNT_W-bit phase counter ph[i] and phase bit open[i].
- Combinational outputs:
  - dst_valid[i] = src_valid[i] & (en[i] | committed[i]).
  - src_ready[i] = dst_valid[i] & dst_ready[i].
  - Zero-latency path; no data buffering.
- committed[i]:
  - Sets when dst_valid & !dst_ready.
  - Clears on handshake (dst_valid & dst_ready).
  - Holds otherwise.
  - Overrides every mode, including stall and mode changes mid-transfer.
- en[i] next value by mode:
  - 0: 1.
  - 1: (lfsr[i][PROB_W-1:0] < prob[i]). prob >= 2^PROB_W gives always 1; prob = 0 gives always 0 (except committed beats).
  - 2: open[i].
  - 3: 0.
- LFSR advances every cycle in all modes, so streams are deterministic for a given SEED and cycle count.
- Periodic mode:
  - Counter sequence: ph counts up to (open ? on_len : off_len) - 1, then wraps to 0 and toggles open.
  - A zero length on the current phase toggles immediately each cycle.
  - on_len = 0 with off_len = 0 gives an alternating pattern.
  - ph and open reset to 0/1 and restart (ph=0, open=1) whenever mode[i] changes.
- Config changes take effect on en one cycle later (registered).
- Reset values:
  - en = 0, committed = 0, ph = 0, open = 1, lfsr = per-channel seed.
  - Hence dst_valid = 0 and src_ready = 0 during and one cycle after reset.
- Reset asserted mid-transfer clears committed; the source is responsible for reset-consistent behaviour.
- Channels are fully independent.
- src_valid dropping without a handshake is a source protocol error. The block then drops dst_valid and clears committed; no error is flagged.

Optional Feature:
- Macro AXI_STALL_STATS_EN.
- Defined, the block adds outputs:
  - hs_cnt (32*N_CH): handshake count, incremented on dst_valid & dst_ready.
  - stall_cnt (32*N_CH): count of src_valid & !src_ready cycles.
  - Both counters reset to 0, saturate at all-ones and do not wrap.
- Undefined: ports and logic are absent; the handshake path is identical.

Decomposition:
- Package axi_stall_pkg holds:
  - typedef enum mode_e {MODE_PASS, MODE_RAND, MODE_PERIOD, MODE_STALL}.
  - LFSR_TAPS.
  - SEED_MIX constant.
  - Function lfsr_next().
- One sub-module, axi_stall_chan, implements a single channel (en, committed, LFSR, phase, optional counters).
- The top generate-loops N_CH instances and slices the flat config buses.

Test Plan:
- Mode 0 on all channels, src_valid held 1, dst_ready 1 -> dst_valid = 1 from the second cycle after rst falls; 100 handshakes in 100 cycles.
- Mode 3, then src_valid = 1 raised -> dst_valid stays 0 for 50 cycles. Switch to mode 0 -> handshake one cycle later.
- Mode 1, prob = 512 (PROB_W = 10), 10000 cycles, dst_ready = 1 -> handshake count within 5000 +/- 250. A rerun with the same SEED gives a bit-identical trace.
- Mode 2, on_len = 3, off_len = 2 -> en pattern 1,1,1,0,0 repeating; mode re-written mid-pattern restarts at open.
- Valid stability: mode 1, prob = 100, dst_ready held 0 for 20 cycles after dst_valid rises; switch to mode 3 meanwhile -> dst_valid stays 1 until dst_ready = 1 completes the beat, then drops.
- Assert rst while committed = 1 -> dst_valid = 0 immediately (async); with AXI_STALL_STATS_EN, hs_cnt and stall_cnt read 0.

Source files
------------

// File: rtl/axi_stall_pkg.sv
// Shared types and helpers for the AXI handshake stall injector.
// Optional statistics counters are enabled with the AXI_STALL_STATS_EN macro.
package axi_stall_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_RAND   = 2'd1,
    MODE_PERIOD = 2'd2,
    MODE_STALL  = 2'd3
  } mode_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_MIX  = 32'h9E37_79B9;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state);
    return {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Decorrelates channel streams; an all-zero LFSR state would lock up.
  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned idx);
    logic [31:0] s;
    s = base ^ (idx * SEED_MIX);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/axi_stall_chan.sv
// One throttled valid/ready channel: enable generator, valid-stability latch, LFSR, phase counter.
// Handshake/stall counters exist only when AXI_STALL_STATS_EN is defined.
module axi_stall_chan
  import axi_stall_pkg::*;
#(
  parameter int          PROB_W    = 10,
  parameter int          CNT_W     = 8,
  parameter logic [31:0] SEED_INIT = 32'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              dst_valid,
  input  logic              dst_ready,
  input  logic [1:0]        mode,
  input  logic [PROB_W:0]   prob,
  input  logic [CNT_W-1:0]  on_len,
  input  logic [CNT_W-1:0]  off_len
`ifdef AXI_STALL_STATS_EN
  ,
  output logic [31:0]       hs_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  mode_e             mode_cur;
  mode_e             mode_prev;
  logic              en;
  logic              en_next;
  logic              committed;
  logic              open;
  logic              open_eff;
  logic              mode_chg;
  logic              wrap;
  logic              rand_hit;
  logic              handshake;
  logic [31:0]       lfsr;
  logic [CNT_W-1:0]  ph;
  logic [CNT_W-1:0]  ph_eff;
  logic [CNT_W-1:0]  len_cur;

  assign mode_cur  = mode_e'(mode);
  assign dst_valid = src_valid & (en | committed);
  assign handshake = dst_valid & dst_ready;
  assign src_ready = handshake;

  // A mode write restarts the periodic pattern at the open phase in the same cycle.
  always_comb begin
    mode_chg = (mode_cur != mode_prev);
    open_eff = mode_chg | open;
    ph_eff   = mode_chg ? '0 : ph;
    len_cur  = open_eff ? on_len : off_len;
    wrap     = ({1'b0, ph_eff} + (CNT_W+1)'(1)) >= {1'b0, len_cur};
    rand_hit = {1'b0, lfsr[PROB_W-1:0]} < prob;
    case (mode_cur)
      MODE_PASS:   en_next = 1'b1;
      MODE_RAND:   en_next = rand_hit;
      MODE_PERIOD: en_next = open_eff;
      default:     en_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en        <= 1'b0;
      committed <= 1'b0;
      lfsr      <= SEED_INIT;
      ph        <= '0;
      open      <= 1'b1;
      mode_prev <= MODE_PASS;
    end else begin
      en        <= en_next;
      // A shown-but-unaccepted beat stays visible; a dropped src_valid releases it.
      committed <= dst_valid & ~dst_ready;
      lfsr      <= lfsr_next(lfsr);
      mode_prev <= mode_cur;
      if (wrap) begin
        ph   <= '0;
        open <= ~open_eff;
      end else begin
        ph   <= ph_eff + CNT_W'(1);
        open <= open_eff;
      end
    end
  end

`ifdef AXI_STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake && (hs_cnt != '1))
        hs_cnt <= hs_cnt + 32'd1;
      if (src_valid && !handshake && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: rtl/axi_stall_injector.sv
// N-channel AXI valid/ready throttle; data buses bypass this block entirely.
// Define AXI_STALL_STATS_EN to add per-channel hs_cnt/stall_cnt outputs.
module axi_stall_injector
  import axi_stall_pkg::*;
#(
  parameter int          N_CH   = 5,
  parameter int          PROB_W = 10,
  parameter int          CNT_W  = 8,
  parameter logic [31:0] SEED   = 32'hACE1_2024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            src_valid,
  output logic [N_CH-1:0]            src_ready,
  output logic [N_CH-1:0]            dst_valid,
  input  logic [N_CH-1:0]            dst_ready,
  input  logic [2*N_CH-1:0]          mode,
  input  logic [(PROB_W+1)*N_CH-1:0] prob,
  input  logic [CNT_W*N_CH-1:0]      on_len,
  input  logic [CNT_W*N_CH-1:0]      off_len
`ifdef AXI_STALL_STATS_EN
  ,
  output logic [32*N_CH-1:0]         hs_cnt,
  output logic [32*N_CH-1:0]         stall_cnt
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    axi_stall_chan #(
      .PROB_W    (PROB_W),
      .CNT_W     (CNT_W),
      .SEED_INIT (chan_seed(SEED, i))
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid[i]),
      .src_ready (src_ready[i]),
      .dst_valid (dst_valid[i]),
      .dst_ready (dst_ready[i]),
      .mode      (mode[2*i +: 2]),
      .prob      (prob[(PROB_W+1)*i +: PROB_W+1]),
      .on_len    (on_len[CNT_W*i +: CNT_W]),
      .off_len   (off_len[CNT_W*i +: CNT_W])
`ifdef AXI_STALL_STATS_EN
      ,
      .hs_cnt    (hs_cnt[32*i +: 32]),
      .stall_cnt (stall_cnt[32*i +: 32])
`endif
    );
  end

endmodule

// File: tb/tb_axi_stall_injector.sv
// Scoreboard bench for axi_stall_injector: a reference model pushes expected handshakes each cycle.
// Optional counters are checked too when AXI_STALL_STATS_EN is defined.
module tb_axi_stall_injector;

  localparam int          N_CH   = 5;
  localparam int          PROB_W = 10;
  localparam int          CNT_W  = 8;
  localparam logic [31:0] SEED   = 32'hACE1_2024;
  localparam logic [31:0] TAPS   = 32'h8020_0003;
  localparam logic [31:0] MIX    = 32'h9E37_79B9;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [N_CH-1:0]            src_valid;
  logic [N_CH-1:0]            src_ready;
  logic [N_CH-1:0]            dst_valid;
  logic [N_CH-1:0]            dst_ready;
  logic [2*N_CH-1:0]          mode;
  logic [(PROB_W+1)*N_CH-1:0] prob;
  logic [CNT_W*N_CH-1:0]      on_len;
  logic [CNT_W*N_CH-1:0]      off_len;
`ifdef AXI_STALL_STATS_EN
  logic [32*N_CH-1:0]         hs_cnt;
  logic [32*N_CH-1:0]         stall_cnt;
`endif

  axi_stall_injector #(
    .N_CH(N_CH), .PROB_W(PROB_W), .CNT_W(CNT_W), .SEED(SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .mode      (mode),
    .prob      (prob),
    .on_len    (on_len),
    .off_len   (off_len)
`ifdef AXI_STALL_STATS_EN
    ,
    .hs_cnt    (hs_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Per-channel configuration and reference model state.
  logic [1:0]  cfg_mode [N_CH];
  int          cfg_prob [N_CH];
  int          cfg_on   [N_CH];
  int          cfg_off  [N_CH];
  logic        m_en     [N_CH];
  logic        m_comm   [N_CH];
  logic        m_open   [N_CH];
  int          m_ph     [N_CH];
  logic [1:0]  m_prev   [N_CH];
  logic [31:0] m_lfsr   [N_CH];
  logic [31:0] m_hs     [N_CH];
  logic [31:0] m_st     [N_CH];

  logic [2*N_CH-1:0] exp_q[$];
  logic [N_CH-1:0]   last_dv;
  logic [N_CH-1:0]   last_sr;
  int                n_vectors;
  int                n_miscompares;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] seedOf(input int idx);
    logic [31:0] s;
    s = SEED ^ (32'(idx) * MIX);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N_CH; i++) begin
      m_en[i]   = 1'b0;
      m_comm[i] = 1'b0;
      m_open[i] = 1'b1;
      m_ph[i]   = 0;
      m_prev[i] = 2'd0;
      m_lfsr[i] = seedOf(i);
      m_hs[i]   = 32'h0;
      m_st[i]   = 32'h0;
    end
  endtask

  task automatic driveCfg();
    for (int i = 0; i < N_CH; i++) begin
      mode[2*i +: 2]                   = cfg_mode[i];
      prob[(PROB_W+1)*i +: PROB_W+1]   = cfg_prob[i][PROB_W:0];
      on_len[CNT_W*i +: CNT_W]         = cfg_on[i][CNT_W-1:0];
      off_len[CNT_W*i +: CNT_W]        = cfg_off[i][CNT_W-1:0];
    end
  endtask

  // Drives one cycle starting at a falling edge, checks outputs, then advances the model.
  task automatic applyStimulus(input logic [N_CH-1:0] sv, input logic [N_CH-1:0] dr);
    logic [N_CH-1:0]   e_dv;
    logic [N_CH-1:0]   e_sr;
    logic [2*N_CH-1:0] got;
    logic              n_en;
    logic              op;
    int                p;
    int                len;
    src_valid = sv;
    dst_ready = dr;
    driveCfg();
    for (int i = 0; i < N_CH; i++) begin
      e_dv[i] = sv[i] & (m_en[i] | m_comm[i]);
      e_sr[i] = e_dv[i] & dr[i];
    end
    exp_q.push_back({e_dv, e_sr});
    #1;
    got     = {dst_valid, src_ready};
    last_dv = dst_valid;
    last_sr = src_ready;
    checkOutput("handshake", 64'(got), 64'(exp_q.pop_front()));
`ifdef AXI_STALL_STATS_EN
    for (int i = 0; i < N_CH; i++) begin
      checkOutput("hs_cnt", 64'(hs_cnt[32*i +: 32]), 64'(m_hs[i]));
      checkOutput("stall_cnt", 64'(stall_cnt[32*i +: 32]), 64'(m_st[i]));
    end
`endif
    for (int i = 0; i < N_CH; i++) begin
      op  = (cfg_mode[i] != m_prev[i]) ? 1'b1 : m_open[i];
      p   = (cfg_mode[i] != m_prev[i]) ? 0 : m_ph[i];
      len = op ? cfg_on[i] : cfg_off[i];
      case (cfg_mode[i])
        2'd0:    n_en = 1'b1;
        2'd1:    n_en = (int'(m_lfsr[i][PROB_W-1:0]) < cfg_prob[i]);
        2'd2:    n_en = op;
        default: n_en = 1'b0;
      endcase
      if (len == 0 || p + 1 >= len) begin
        m_ph[i]   = 0;
        m_open[i] = ~op;
      end else begin
        m_ph[i]   = p + 1;
        m_open[i] = op;
      end
      if (e_sr[i])
        m_comm[i] = 1'b0;
      else if (e_dv[i])
        m_comm[i] = 1'b1;
      else if (!sv[i])
        m_comm[i] = 1'b0;
      if (e_sr[i] && m_hs[i] != 32'hFFFF_FFFF)
        m_hs[i] = m_hs[i] + 32'd1;
      if (sv[i] && !e_sr[i] && m_st[i] != 32'hFFFF_FFFF)
        m_st[i] = m_st[i] + 32'd1;
      m_lfsr[i] = m_lfsr[i][0] ? ({1'b0, m_lfsr[i][31:1]} ^ TAPS) : {1'b0, m_lfsr[i][31:1]};
      m_en[i]   = n_en;
      m_prev[i] = cfg_mode[i];
    end
    @(negedge clk);
  endtask

  // Asserts reset asynchronously at a falling edge; outputs must drop at once.
  task automatic doReset(input int cycles);
    rst = 1'b1;
    #1;
    checkOutput("rst_dv", 64'(dst_valid), 64'h0);
    checkOutput("rst_sr", 64'(src_ready), 64'h0);
`ifdef AXI_STALL_STATS_EN
    checkOutput("rst_hs_cnt", 64'(hs_cnt), 64'h0);
    checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'h0);
`endif
    repeat (cycles) @(negedge clk);
    modelReset();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int waited;
    logic [N_CH-1:0] dr;
    n_vectors     = 0;
    n_miscompares = 0;
    rst       = 1'b1;
    src_valid = '0;
    dst_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      cfg_mode[i] = 2'd0;
      cfg_prob[i] = 0;
      cfg_on[i]   = 0;
      cfg_off[i]  = 0;
    end
    driveCfg();
    modelReset();
    @(negedge clk);
    doReset(2);

    // Pass-through: first cycle after reset is closed, then one beat per cycle.
    cnt = 0;
    for (int k = 0; k < 101; k++) begin
      applyStimulus('1, '1);
      if (last_sr[0]) cnt++;
    end
    checkOutput("pass_hs_count", 64'(cnt), 64'd100);

    // Stall mode holds everything closed; releasing to pass takes one cycle.
    for (int i = 0; i < N_CH; i++) cfg_mode[i] = 2'd3;
    applyStimulus('0, '1);
    applyStimulus('0, '1);
    for (int k = 0; k < 50; k++) begin
      applyStimulus('1, '1);
      checkOutput("stall_dv", 64'(last_dv), 64'h0);
    end
    for (int i = 0; i < N_CH; i++) cfg_mode[i] = 2'd0;
    applyStimulus('1, '1);
    checkOutput("release_first", 64'(last_dv[0]), 64'h0);
    applyStimulus('1, '1);
    checkOutput("release_hs", 64'(last_sr[0]), 64'h1);

    // Random mode: ~50% on channel 0, saturated and zero probabilities elsewhere.
    for (int i = 0; i < N_CH; i++) cfg_mode[i] = 2'd1;
    cfg_prob[0] = 512;
    cfg_prob[1] = 2047;
    cfg_prob[2] = 0;
    cfg_prob[3] = 100;
    cfg_prob[4] = 1024;
    cnt = 0;
    for (int k = 0; k < 10000; k++) begin
      dr    = N_CH'($urandom);
      dr[0] = 1'b1;
      applyStimulus('1, dr);
      if (last_sr[0]) cnt++;
    end
    checkOutput("rand_hs_window", 64'((cnt >= 4750) && (cnt <= 5250)), 64'h1);

    // Periodic: 3 open / 2 closed on channel 0, degenerate lengths elsewhere.
    cfg_mode[0] = 2'd2; cfg_on[0] = 3; cfg_off[0] = 2;
    cfg_mode[1] = 2'd2; cfg_on[1] = 0; cfg_off[1] = 0;
    cfg_mode[2] = 2'd2; cfg_on[2] = 0; cfg_off[2] = 2;
    cfg_mode[3] = 2'd2; cfg_on[3] = 1; cfg_off[3] = 4;
    applyStimulus('1, '1);
    for (int k = 0; k < 12; k++) begin
      applyStimulus('1, '1);
      checkOutput("period_pattern", 64'(last_dv[0]), 64'((k % 5) < 3));
    end
    cfg_mode[0] = 2'd0;
    applyStimulus('1, '1);
    cfg_mode[0] = 2'd2;
    applyStimulus('1, '1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus('1, '1);
      checkOutput("period_restart", 64'(last_dv[0]), 64'((k % 5) < 3));
    end

    // Valid stability: once shown, a beat survives a switch to stall mode.
    cfg_mode[0] = 2'd1;
    cfg_prob[0] = 100;
    waited = 0;
    do begin
      applyStimulus('1, 5'b11110);
      waited++;
    end while (!last_dv[0] && waited < 300);
    checkOutput("stab_rise_seen", 64'(last_dv[0]), 64'h1);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) cfg_mode[0] = 2'd3;
      applyStimulus('1, 5'b11110);
      checkOutput("stab_hold", 64'(last_dv[0]), 64'h1);
    end
    applyStimulus('1, '1);
    checkOutput("stab_complete", 64'(last_sr[0]), 64'h1);
    applyStimulus('1, '1);
    checkOutput("stab_drop", 64'(last_dv[0]), 64'h0);

    // Reset while a beat is committed.
    cfg_mode[0] = 2'd0;
    for (int k = 0; k < 4; k++) applyStimulus('1, 5'b11110);
    checkOutput("pre_rst_committed", 64'(dst_valid[0]), 64'h1);
    doReset(2);
    for (int k = 0; k < 5; k++) applyStimulus('1, '1);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
